sd_block_buffer: RTL
====================

SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, giving the cycles allowed from sd_execute assertion to sd_finished_block before an error.
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, giving the bytes per sector.
REQ-003 SHALL use one clock and an asynchronous active-low reset; all logic SHALL be on the posedge of clk.
REQ-004 clk  in  1  master clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 host_req  in  1  start a sector op; sampled only in IDLE.
REQ-007 host_op  in  1  0=READ (card to buffer), 1=WRITE (buffer to card).
REQ-008 host_lba  in  32  sector address, latched with host_req.
REQ-009 host_busy  out  1  high in every state except IDLE.
REQ-010 host_done  out  1  one-cycle pulse at op end.
REQ-011 host_err  out  1  sticky error flag, valid with host_done, cleared by next accepted host_req.
REQ-012 buf_addr  in  9  host buffer address.
REQ-013 buf_wdata  in  8  host write data.
REQ-014 buf_we  in  1  host write strobe.
REQ-015 buf_rdata  out  8  host read data, one-cycle latency.
REQ-016 sd_execute, sd_op_code  out  1,1  controller start and op select.
REQ-017 sd_block_address  out  32  latched host_lba.
REQ-018 sd_busy  in  1  controller busy.
REQ-019 sd_incoming_byte  in  8  read data from the controller.
REQ-020 sd_finished_byte, sd_finished_block  in  1,1  single-cycle pulses from the controller.
REQ-021 sd_outgoing_byte  out  8  write data to the controller.

Function
REQ-022 SHALL implement states IDLE, WAIT_READY, ISSUE, XFER, DONE.
REQ-023 IDLE: on host_req=1, SHALL latch host_op and host_lba, clear host_err, zero byte_cnt, and go to WAIT_READY; host_req outside IDLE SHALL be ignored.
REQ-024 WAIT_READY: when sd_busy=0, SHALL go to ISSUE.
REQ-025 ISSUE: SHALL assert sd_execute=1 with sd_op_code stable, and hold it until sd_busy=1 is sampled; SHALL then deassert sd_execute and go to XFER.
REQ-026 XFER READ: each sd_finished_byte pulse SHALL write sd_incoming_byte to buffer[byte_cnt] and increment byte_cnt.
REQ-027 XFER WRITE: sd_outgoing_byte SHALL show buffer[0] by entry to XFER; each sd_finished_byte pulse SHALL increment byte_cnt, and sd_outgoing_byte SHALL show buffer[byte_cnt] within 2 cycles.
REQ-028 byte_cnt SHALL be 10 bits and saturate at BLOCK_BYTES; pulses at saturation SHALL write nothing.
REQ-029 On an sd_finished_block pulse SHALL go to DONE; for READ, host_err SHALL be set if final byte_cnt != BLOCK_BYTES.
REQ-030 If sd_finished_byte and sd_finished_block pulse in the same cycle, the byte SHALL be stored and counted before the count check.
REQ-031 A timeout counter SHALL start at sd_execute assertion; reaching TIMEOUT_CYCLES in ISSUE or XFER SHALL set host_err, deassert sd_execute, and go to DONE.
REQ-032 DONE: SHALL pulse host_done for one cycle and return to IDLE.
REQ-033 Host buf_we SHALL write the buffer only when host_busy=0; buf_we while busy SHALL be dropped.
REQ-034 Host reads SHALL be allowed at all times; data read during READ XFER is undefined.

Reset
REQ-035 rst_n low SHALL force IDLE, with host_busy, host_done, host_err, sd_execute, sd_op_code, byte_cnt, timeout counter = 0, sd_block_address = 0, and sd_outgoing_byte = 8'hff.
REQ-036 Reset mid-op SHALL abort with no host_done; buffer RAM contents SHALL be retained and not reset.

Structure
REQ-037 Package sd_pkg SHALL hold the state encoding, BLOCK_BYTES, and the OP_READ/OP_WRITE constants.
REQ-038 Storage SHALL be the sub-module sd_sector_ram: 512x8, host port A read/write, controller port B read/write, synchronous read, no reset.

Verification
REQ-039 Host writes 0..511 = addr[7:0], WRITE lba=32'h10 -> sd_block_address=32'h10, sd_op_code=1, bytes 0..511 appear in order on sd_outgoing_byte, host_done with host_err=0.
REQ-040 READ with model feeding 512 bytes 8'hA5^i, last byte coincident with finished_block -> buffer matches, host_err=0.
REQ-041 READ with finished_block after 300 bytes -> host_done with host_err=1.
REQ-042 sd_busy stuck 0 after execute, TIMEOUT_CYCLES=1000 -> host_err=1 exactly 1000 cycles after sd_execute rise, then sd_execute=0.
REQ-043 rst_n low mid-XFER -> IDLE, sd_execute=0 next cycle, no host_done; a new op then completes normally.
REQ-044 host_req and buf_we pulsed while busy -> ignored; buffer unchanged.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector buffer: FSM encoding,
// sector size, controller op codes and the byte-counter step helper.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_XFER       = 3'd3,
    ST_DONE       = 3'd4
  } sd_state_e;

  localparam int   BLOCK_BYTES = 512;
  localparam int   RAM_ADDR_W  = 9;
  localparam int   CNT_W       = 10;
  localparam logic OP_READ     = 1'b0;
  localparam logic OP_WRITE    = 1'b1;

  // Saturating byte counter: a pulse at the limit leaves the count alone.
  function automatic logic [CNT_W-1:0] byte_cnt_step(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] limit,
    input logic             pulse
  );
    logic [CNT_W-1:0] nxt;
    if (pulse && (cnt < limit)) begin
      nxt = cnt + 10'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sd_block_buffer_if.sv
// Host-side and SD-controller-side signal bundle of the sector buffer.
// The slave modport is the buffer's view; master is the host/controller view.
interface sd_block_buffer_if;
  logic        host_req;
  logic        host_op;
  logic [31:0] host_lba;
  logic        host_busy;
  logic        host_done;
  logic        host_err;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        buf_we;
  logic [7:0]  buf_rdata;
  logic        sd_execute;
  logic        sd_op_code;
  logic [31:0] sd_block_address;
  logic        sd_busy;
  logic [7:0]  sd_incoming_byte;
  logic        sd_finished_byte;
  logic        sd_finished_block;
  logic [7:0]  sd_outgoing_byte;

  modport slave (
    input  host_req, host_op, host_lba, buf_addr, buf_wdata, buf_we,
           sd_busy, sd_incoming_byte, sd_finished_byte, sd_finished_block,
    output host_busy, host_done, host_err, buf_rdata,
           sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte
  );

  modport master (
    output host_req, host_op, host_lba, buf_addr, buf_wdata, buf_we,
           sd_busy, sd_incoming_byte, sd_finished_byte, sd_finished_block,
    input  host_busy, host_done, host_err, buf_rdata,
           sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte
  );
endinterface

// File: rtl/sd_sector_ram.sv
// 512x8 dual-port sector RAM, synchronous read on both ports, no reset.
// Port A belongs to the host, port B to the SD controller path.
module sd_sector_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_a_r;
  logic [DATA_W-1:0] rdata_b_r;

  // Array writes; the two ports are never enabled together by the owner.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem_r[addr_b] <= wdata_b;
    end else if (we_a) begin
      mem_r[addr_a] <= wdata_a;
    end
  end

  // Registered read-first outputs for both ports.
  always_ff @(posedge clk) begin
    rdata_a_r <= mem_r[addr_a];
    rdata_b_r <= mem_r[addr_b];
  end

  assign rdata_a = rdata_a_r;
  assign rdata_b = rdata_b_r;

endmodule

// File: rtl/sd_block_buffer.sv
// Sector buffer between a host and an SD block controller: sequences one
// sector read or write through the controller handshake with a timeout.
module sd_block_buffer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int          BLOCK_BYTES    = sd_pkg::BLOCK_BYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_block_buffer_if.slave   bus
);
  import sd_pkg::*;

  localparam logic [CNT_W-1:0] BLK_LIMIT = CNT_W'(BLOCK_BYTES);

  sd_state_e          state_r;
  logic [CNT_W-1:0]   byte_cnt_r;
  logic [23:0]        tmo_cnt_r;
  logic               host_busy_r;
  logic               host_done_r;
  logic               host_err_r;
  logic               sd_execute_r;
  logic               sd_op_code_r;
  logic [31:0]        sd_block_address_r;
  logic [7:0]         sd_outgoing_byte_r;

  logic [CNT_W-1:0]      byte_cnt_nxt_s;
  logic                  in_xfer_s;
  logic                  tmo_hit_s;
  logic                  ram_we_a_s;
  logic                  ram_we_b_s;
  logic [RAM_ADDR_W-1:0] ram_addr_b_s;
  logic [7:0]            ram_rdata_a_s;
  logic [7:0]            ram_rdata_b_s;

  // Datapath decode: byte counting, RAM port control, timeout detect.
  always_comb begin
    in_xfer_s      = (state_r == ST_XFER);
    byte_cnt_nxt_s = byte_cnt_step(byte_cnt_r, BLK_LIMIT, in_xfer_s && bus.sd_finished_byte);
    tmo_hit_s      = (tmo_cnt_r == (TIMEOUT_CYCLES - 24'd1));
    ram_we_a_s     = bus.buf_we && !host_busy_r;
    ram_we_b_s     = in_xfer_s && (sd_op_code_r == OP_READ) && bus.sd_finished_byte
                     && (byte_cnt_r < BLK_LIMIT);
    // Writes look ahead so the next outgoing byte is fetched during the pulse.
    if (sd_op_code_r == OP_READ) begin
      ram_addr_b_s = byte_cnt_r[RAM_ADDR_W-1:0];
    end else begin
      ram_addr_b_s = byte_cnt_nxt_s[RAM_ADDR_W-1:0];
    end
  end

  sd_sector_ram #(
    .ADDR_W (RAM_ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk     (clk),
    .we_a    (ram_we_a_s),
    .addr_a  (bus.buf_addr),
    .wdata_a (bus.buf_wdata),
    .rdata_a (ram_rdata_a_s),
    .we_b    (ram_we_b_s),
    .addr_b  (ram_addr_b_s),
    .wdata_b (bus.sd_incoming_byte),
    .rdata_b (ram_rdata_b_s)
  );

  // Sector operation FSM with all host/controller handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      byte_cnt_r         <= 10'd0;
      tmo_cnt_r          <= 24'd0;
      host_busy_r        <= 1'b0;
      host_done_r        <= 1'b0;
      host_err_r         <= 1'b0;
      sd_execute_r       <= 1'b0;
      sd_op_code_r       <= 1'b0;
      sd_block_address_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          host_done_r <= 1'b0;
          if (bus.host_req) begin
            sd_op_code_r       <= bus.host_op;
            sd_block_address_r <= bus.host_lba;
            host_err_r         <= 1'b0;
            byte_cnt_r         <= 10'd0;
            host_busy_r        <= 1'b1;
            state_r            <= ST_WAIT_READY;
          end
        end
        ST_WAIT_READY: begin
          if (!bus.sd_busy) begin
            sd_execute_r <= 1'b1;
            tmo_cnt_r    <= 24'd0;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (tmo_hit_s) begin
            host_err_r   <= 1'b1;
            sd_execute_r <= 1'b0;
            host_done_r  <= 1'b1;
            state_r      <= ST_DONE;
          end else if (bus.sd_busy) begin
            sd_execute_r <= 1'b0;
            tmo_cnt_r    <= tmo_cnt_r + 24'd1;
            state_r      <= ST_XFER;
          end else begin
            tmo_cnt_r    <= tmo_cnt_r + 24'd1;
          end
        end
        ST_XFER: begin
          byte_cnt_r <= byte_cnt_nxt_s;
          // The count check uses the post-increment value so a coincident byte counts.
          if (bus.sd_finished_block) begin
            host_done_r <= 1'b1;
            state_r     <= ST_DONE;
            if ((sd_op_code_r == OP_READ) && (byte_cnt_nxt_s != BLK_LIMIT)) begin
              host_err_r <= 1'b1;
            end
          end else if (tmo_hit_s) begin
            host_err_r  <= 1'b1;
            host_done_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            tmo_cnt_r   <= tmo_cnt_r + 24'd1;
          end
        end
        ST_DONE: begin
          host_done_r <= 1'b0;
          host_busy_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          host_done_r  <= 1'b0;
          host_busy_r  <= 1'b0;
          sd_execute_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Outgoing write byte tracks the look-ahead RAM read while a write is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_outgoing_byte_r <= 8'hff;
    end else if (((state_r == ST_ISSUE) || (state_r == ST_XFER)) && (sd_op_code_r == OP_WRITE)) begin
      sd_outgoing_byte_r <= ram_rdata_b_s;
    end else if (state_r == ST_IDLE) begin
      sd_outgoing_byte_r <= 8'hff;
    end
  end

  assign bus.host_busy        = host_busy_r;
  assign bus.host_done        = host_done_r;
  assign bus.host_err         = host_err_r;
  assign bus.buf_rdata        = ram_rdata_a_s;
  assign bus.sd_execute       = sd_execute_r;
  assign bus.sd_op_code       = sd_op_code_r;
  assign bus.sd_block_address = sd_block_address_r;
  assign bus.sd_outgoing_byte = sd_outgoing_byte_r;

endmodule
